// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer.
// Carries NUM_DATA datapath fields plus a control vector whose masked bits read 0 on bubbles.
module pipe_stage_reg #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    NUM_DATA       = 3,
    parameter int                    CTRL_WIDTH     = 16,
    parameter int                    SKID           = 1,
    parameter logic [CTRL_WIDTH-1:0] CTRL_KILL_MASK = '1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_DATA*DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0]          in_ctrl,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_DATA*DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0]          out_ctrl,
    input  logic                           stall,
    input  logic                           flush,
    output logic [1:0]                     occupancy
);

    localparam int PW = NUM_DATA * DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  vld_p1;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;
    logic [PW-1:0]         data_p1;
    logic [CTRL_WIDTH-1:0] ctrl_p1;
    logic [PW-1:0]         skid_data_p1;
    logic [CTRL_WIDTH-1:0] skid_ctrl_p1;

    assign vld_p1   = (state_q != ST_EMPTY);
    assign out_xfer = vld_p1 & out_ready & ~stall;
    assign in_xfer  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush wins over every transfer; loads are suppressed so held data is untouched.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end else if (in_xfer && SKID != 0) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = vld_p1;
        out_data  = data_p1;
        out_ctrl  = vld_p1 ? ctrl_p1 : (ctrl_p1 & ~CTRL_KILL_MASK);
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // ---- stage p1: main and skid entry registers ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_p1      <= '0;
            ctrl_p1      <= '0;
            skid_data_p1 <= '0;
            skid_ctrl_p1 <= '0;
        end else begin
            if (load_main_in) begin
                data_p1 <= in_data;
                ctrl_p1 <= in_ctrl;
            end else if (load_main_skid) begin
                data_p1 <= skid_data_p1;
                ctrl_p1 <= skid_ctrl_p1;
            end
            if (load_skid) begin
                skid_data_p1 <= in_data;
                skid_ctrl_p1 <= in_ctrl;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Registered ready breaks the out_ready/stall -> in_ready timing path.
            logic in_ready_q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= (state_d != ST_FULL);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = rstn & (~vld_p1 | (out_ready & ~stall));
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus and are
// each compared against a small FIFO reference model (capacity 2 and 1).
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int ND = 3;
    localparam int CW = 16;
    localparam int PW = DW * ND;
    localparam logic [CW-1:0] MASK_S = 16'hFFFF;
    localparam logic [CW-1:0] MASK_N = 16'h00FF;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid, out_ready, stall, flush;
    logic [PW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          s_in_ready, s_out_valid, n_in_ready, n_out_valid;
    logic [PW-1:0] s_out_data, n_out_data;
    logic [CW-1:0] s_out_ctrl, n_out_ctrl;
    logic [1:0]    s_occupancy, n_occupancy;

    pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_DATA(ND), .CTRL_WIDTH(CW), .SKID(1),
                     .CTRL_KILL_MASK(MASK_S)) dut_s (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stall(stall), .flush(flush), .occupancy(s_occupancy));

    pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_DATA(ND), .CTRL_WIDTH(CW), .SKID(0),
                     .CTRL_KILL_MASK(MASK_N)) dut_n (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(n_out_valid),
        .out_ready(out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
        .stall(stall), .flush(flush), .occupancy(n_occupancy));

    typedef struct packed {
        logic [PW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    // Model index 1 = SKID=1 instance, index 0 = SKID=0 instance.
    ent_t e [2][2];
    int   cnt [2];
    ent_t last [2];
    logic rdy1;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic mdl_ready(input int i);
        if (!rstn) return 1'b0;
        if (i == 1) return rdy1;
        return (cnt[0] == 0) || (out_ready && !stall);
    endfunction

    function automatic logic [CW-1:0] exp_ctrl(input int i);
        logic [CW-1:0] m;
        m = (i == 1) ? MASK_S : MASK_N;
        return (cnt[i] > 0) ? last[i].c : (last[i].c & ~m);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cnt[i]  = 0;
            last[i] = '0;
        end
        rdy1 = 1'b0;
    endtask

    task automatic model_edge(input int i, input logic r);
        logic pop;
        logic push;
        if (flush) begin
            cnt[i] = 0;
        end else begin
            pop  = (cnt[i] > 0) && out_ready && !stall;
            push = in_valid && r;
            if (pop) begin
                e[i][0] = e[i][1];
                cnt[i]--;
            end
            if (push) begin
                e[i][cnt[i]] = {in_data, in_ctrl};
                cnt[i]++;
            end
            if (cnt[i] > 0) last[i] = e[i][0];
        end
        if (i == 1) rdy1 = (cnt[1] < 2);
    endtask

    task automatic check_outputs();
        chk("s_out_valid", s_out_valid, cnt[1] > 0);
        chk("s_out_data",  s_out_data,  last[1].d);
        chk("s_out_ctrl",  s_out_ctrl,  exp_ctrl(1));
        chk("s_occupancy", s_occupancy, cnt[1]);
        chk("n_out_valid", n_out_valid, cnt[0] > 0);
        chk("n_out_data",  n_out_data,  last[0].d);
        chk("n_out_ctrl",  n_out_ctrl,  exp_ctrl(0));
        chk("n_occupancy", n_occupancy, cnt[0]);
    endtask

    task automatic check_ready();
        chk("s_in_ready", s_in_ready, mdl_ready(1));
        chk("n_in_ready", n_in_ready, mdl_ready(0));
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic st, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
    endtask

    task automatic cycle();
        logic r0;
        logic r1;
        #1;
        check_ready();
        r0 = mdl_ready(0);
        r1 = mdl_ready(1);
        @(posedge clk);
        model_edge(0, r0);
        model_edge(1, r1);
        #1;
        check_outputs();
    endtask

    function automatic logic [PW-1:0] pat(input int k);
        return {DW'(k + 200), DW'(k + 100), DW'(k)};
    endfunction

    initial begin
        drive(0, '0, '0, 0, 0, 0);
        model_reset();
        #2;
        check_outputs();
        check_ready();
        @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
        check_ready();
        cycle();

        // stream 1..8 with downstream always ready
        for (int k = 1; k <= 8; k++) begin
            drive(1, pat(k), CW'(16'h0A00 + k), 1, 0, 0);
            cycle();
        end
        drive(0, '0, '0, 1, 0, 0);
        cycle();
        cycle();

        // backpressure: A then B (and C refused) with out_ready low, then drain in order
        drive(1, pat(21), 16'hA1A1, 0, 0, 0); cycle();
        drive(1, pat(22), 16'hB2B2, 0, 0, 0); cycle();
        drive(1, pat(23), 16'hC3C3, 0, 0, 0); cycle();
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, '0, 1, 0, 0);
            cycle();
        end

        // stall for 3 cycles while upstream keeps offering
        drive(1, pat(31), 16'h3131, 1, 0, 0); cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1, pat(32 + k), 16'h3232, 1, 1, 0);
            cycle();
        end
        drive(1, pat(40), 16'h4040, 1, 0, 0); cycle();
        drive(0, '0, '0, 1, 0, 0); cycle(); cycle();

        // flush in FULL with a simultaneous offer
        drive(1, pat(51), 16'h5151, 0, 0, 0); cycle();
        drive(1, pat(52), 16'h5252, 0, 0, 0); cycle();
        drive(1, pat(53), 16'h5353, 0, 0, 1); cycle();
        drive(0, '0, '0, 1, 0, 0); cycle(); cycle();

        // async reset pulse between edges mid-stream
        drive(1, pat(61), 16'h6161, 0, 0, 0); cycle();
        drive(1, pat(62), 16'h6262, 0, 0, 0); cycle();
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_ready();
        rstn = 1'b1;
        #1;
        check_ready();
        drive(1, pat(63), 16'h6363, 1, 0, 0); cycle();
        drive(1, pat(64), 16'h6464, 1, 0, 0); cycle();
        drive(0, '0, '0, 1, 0, 0); cycle(); cycle();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0,
                  {DW'($urandom), DW'($urandom), DW'($urandom)}, CW'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 24) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
